// File: rtl/phase_host.sv
// Host-side sequencer for the phase engine: loads a slab, starts one phase, streams the result back.
// Optional WAIT watchdog enabled by defining PHASE_HOST_TIMEOUT_EN.
module phase_host #(
    parameter int N       = 4,
    parameter int M       = 2,
    parameter int L       = 8,
    parameter int K       = 16,
    parameter int TIMEOUT = 4096,
    localparam int W      = N * $clog2(M),
    localparam int DEPTH  = L * K / N,
    localparam int AW     = $clog2(DEPTH),
    localparam int SBW    = $clog2(K / N + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_go,
    input  logic [SBW-1:0] i_go_block,
    input  logic           i_go_last,
    output logic           o_busy,
    input  logic           i_in_valid,
    output logic           o_in_ready,
    input  logic [W-1:0]   i_in_data,
    output logic           o_out_valid,
    input  logic           i_out_ready,
    output logic [W-1:0]   o_out_data,
    output logic           o_result_done,
    output logic           o_result_fail,
    output logic           o_ph_start,
    output logic           o_ph_last_phase,
    output logic [SBW-1:0] o_ph_start_block,
    input  logic           i_ph_done,
    input  logic           i_ph_fail,
    output logic           o_ph_wr_en,
    output logic [AW-1:0]  o_ph_wr_addr,
    output logic [W-1:0]   o_ph_data_in,
    output logic           o_ph_rd_en,
    output logic [AW-1:0]  o_ph_rd_addr,
    input  logic [W-1:0]   i_ph_data_out
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KICK, S_WAIT, S_UNLOAD} state_t;

    localparam logic [AW:0] LAST_IDX = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0] DEPTH_C  = (AW + 1)'(DEPTH);

    state_t         r_state;
    state_t         w_next;
    logic [AW:0]    r_wr_cnt;
    logic [AW:0]    r_rd_cnt;
    logic [AW:0]    r_pop_cnt;
    logic [SBW-1:0] r_block;
    logic           r_last;
    logic [W-1:0]   r_q0;
    logic [W-1:0]   r_q1;
    logic [1:0]     r_cnt;
    logic           r_inflight;
    logic           r_result_done;
    logic           r_result_fail;

    logic           w_in_hs;
    logic           w_has;
    logic           w_pop;
    logic [2:0]     w_occ;
    logic           w_rd_en;
    logic           w_timeout;
    logic           w_fail_evt;

`ifdef PHASE_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_to_cnt <= '0;
        else if (r_state != S_WAIT)
            r_to_cnt <= '0;
        else
            r_to_cnt <= r_to_cnt + 1'b1;
    end

    assign w_timeout = (r_state == S_WAIT) && (r_to_cnt == TW'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_in_hs    = (r_state == S_LOAD) && i_in_valid;
    assign w_has      = (r_cnt != 2'd0);
    assign w_pop      = w_has && i_out_ready;
    assign w_fail_evt = (r_state == S_WAIT) && (i_ph_fail || w_timeout);

    // Occupancy net of this cycle's pop, so a steady drain keeps one read per cycle.
    assign w_occ   = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_en = (r_state == S_UNLOAD) && (w_occ < 3'd2) && (r_rd_cnt < DEPTH_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_go) w_next = S_LOAD;
            S_LOAD:   if (w_in_hs && r_wr_cnt == LAST_IDX) w_next = S_KICK;
            S_KICK:   w_next = S_WAIT;
            S_WAIT: begin
                if (w_fail_evt)
                    w_next = S_IDLE;
                else if (i_ph_done)
                    w_next = S_UNLOAD;
            end
            S_UNLOAD: if (w_pop && r_pop_cnt == LAST_IDX) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy       = (r_state != S_IDLE);
        o_in_ready   = (r_state == S_LOAD);
        o_ph_start   = (r_state == S_KICK);
        o_ph_wr_en   = 1'b0;
        o_ph_wr_addr = '0;
        o_ph_data_in = '0;
        o_ph_rd_en   = 1'b0;
        o_ph_rd_addr = '0;
        if (w_in_hs) begin
            o_ph_wr_en   = 1'b1;
            o_ph_wr_addr = r_wr_cnt[AW-1:0];
            o_ph_data_in = i_in_data;
        end
        if (w_rd_en) begin
            o_ph_rd_en   = 1'b1;
            o_ph_rd_addr = r_rd_cnt[AW-1:0];
        end
    end

    assign o_out_valid      = w_has;
    assign o_out_data       = r_q0;
    assign o_result_done    = r_result_done;
    assign o_result_fail    = r_result_fail;
    assign o_ph_start_block = r_block;
    assign o_ph_last_phase  = r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt      <= '0;
            r_rd_cnt      <= '0;
            r_pop_cnt     <= '0;
            r_block       <= '0;
            r_last        <= 1'b0;
            r_q0          <= '0;
            r_q1          <= '0;
            r_cnt         <= 2'd0;
            r_inflight    <= 1'b0;
            r_result_done <= 1'b0;
            r_result_fail <= 1'b0;
        end else begin
            r_result_done <= (r_state == S_UNLOAD) && w_pop && (r_pop_cnt == LAST_IDX);
            r_result_fail <= w_fail_evt;
            r_inflight    <= w_rd_en;
            case (r_state)
                S_IDLE: begin
                    if (i_go) begin
                        r_block  <= i_go_block;
                        r_last   <= i_go_last;
                        r_wr_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_in_hs)
                        r_wr_cnt <= r_wr_cnt + 1'b1;
                end
                S_WAIT: begin
                    if (!w_fail_evt && i_ph_done) begin
                        r_rd_cnt  <= '0;
                        r_pop_cnt <= '0;
                        r_cnt     <= 2'd0;
                        r_q0      <= '0;
                        r_q1      <= '0;
                    end
                end
                S_UNLOAD: begin
                    if (w_rd_en)
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                    if (w_pop)
                        r_pop_cnt <= r_pop_cnt + 1'b1;
                    // r_inflight marks the read issued last cycle, whose data is on i_ph_data_out now.
                    case ({r_inflight, w_pop})
                        2'b10: begin
                            if (r_cnt == 2'd0)
                                r_q0 <= i_ph_data_out;
                            else
                                r_q1 <= i_ph_data_out;
                            r_cnt <= r_cnt + 2'd1;
                        end
                        2'b01: begin
                            r_q0  <= r_q1;
                            r_cnt <= r_cnt - 2'd1;
                        end
                        2'b11: begin
                            if (r_cnt == 2'd1) begin
                                r_q0 <= i_ph_data_out;
                            end else begin
                                r_q0 <= r_q1;
                                r_q1 <= i_ph_data_out;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_phase_host.sv
// Randomised self-checking bench for phase_host with a behavioural phase-engine model.
module tb_phase_host;

    localparam int W     = 4;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int SBW   = 3;
    localparam int TO    = 64;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           i_go;
    logic [SBW-1:0] i_go_block;
    logic           i_go_last;
    logic           o_busy;
    logic           i_in_valid;
    logic           o_in_ready;
    logic [W-1:0]   i_in_data;
    logic           o_out_valid;
    logic           i_out_ready;
    logic [W-1:0]   o_out_data;
    logic           o_result_done;
    logic           o_result_fail;
    logic           o_ph_start;
    logic           o_ph_last_phase;
    logic [SBW-1:0] o_ph_start_block;
    logic           i_ph_done;
    logic           i_ph_fail;
    logic           o_ph_wr_en;
    logic [AW-1:0]  o_ph_wr_addr;
    logic [W-1:0]   o_ph_data_in;
    logic           o_ph_rd_en;
    logic [AW-1:0]  o_ph_rd_addr;
    logic [W-1:0]   i_ph_data_out;

    phase_host #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_go(i_go), .i_go_block(i_go_block), .i_go_last(i_go_last), .o_busy(o_busy),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_data(i_in_data),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
        .o_result_done(o_result_done), .o_result_fail(o_result_fail),
        .o_ph_start(o_ph_start), .o_ph_last_phase(o_ph_last_phase), .o_ph_start_block(o_ph_start_block),
        .i_ph_done(i_ph_done), .i_ph_fail(i_ph_fail),
        .o_ph_wr_en(o_ph_wr_en), .o_ph_wr_addr(o_ph_wr_addr), .o_ph_data_in(o_ph_data_in),
        .o_ph_rd_en(o_ph_rd_en), .o_ph_rd_addr(o_ph_rd_addr), .i_ph_data_out(i_ph_data_out)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // job-level model state
    logic [W-1:0] exp_q [DEPTH];
    logic [W-1:0] mem   [DEPTH];
    logic [W-1:0] pending;
    int cyc = 0;
    int in_idx, wr_seen, rd_issued, pop_idx;
    bit gap_en;
    int out_mode;
    int resp_mode, resp_delay, arm_cnt;
    bit armed;
    int start_cnt, start_cyc, done_cyc;
    int res_done_cnt, res_fail_cnt, res_done_cyc, res_fail_cyc;
    int first_ov_cyc, ov_cnt;
    bit busy_at_fail;
    bit go_req, ign_go;
    logic [SBW-1:0] job_block;
    logic job_last;

    task automatic tick();
        bit pop;
        @(negedge clk);
        cyc++;
        i_go = 1'b0;
        if (go_req) begin
            i_go = 1'b1; i_go_block = job_block; i_go_last = job_last; go_req = 0;
        end else if (ign_go && in_idx == 8) begin
            i_go = 1'b1; i_go_block = 3'd3; i_go_last = ~job_last; ign_go = 0;
        end
        i_in_valid = 1'b0;
        i_in_data  = W'($urandom);
        if (in_idx < DEPTH && !(gap_en && (cyc % 3 == 0))) begin
            i_in_valid = 1'b1;
            i_in_data  = exp_q[in_idx];
        end
        case (out_mode)
            0:       i_out_ready = 1'b1;
            1:       i_out_ready = (cyc % 2 == 0);
            default: i_out_ready = 1'($urandom);
        endcase
        i_ph_data_out = pending;
        i_ph_done = 1'b0;
        i_ph_fail = 1'b0;
        if (armed) begin
            if (arm_cnt == resp_delay) begin
                armed = 0;
                if (resp_mode == 0) begin
                    i_ph_done = 1'b1; done_cyc = cyc;
                end else if (resp_mode == 1) begin
                    i_ph_done = 1'b1; i_ph_fail = 1'b1; done_cyc = cyc;
                end
            end else begin
                arm_cnt++;
            end
        end
        #1;
        if (o_ph_wr_en) begin
            check("wr_hs", 32'(i_in_valid && o_in_ready), 1);
            check("wr_addr", 32'(o_ph_wr_addr), wr_seen);
            if (wr_seen < DEPTH) check("wr_data", 32'(o_ph_data_in), 32'(exp_q[wr_seen]));
            mem[o_ph_wr_addr] = o_ph_data_in;
            wr_seen++;
        end
        if (i_in_valid && o_in_ready) in_idx++;
        if (o_ph_start) begin
            start_cnt++; start_cyc = cyc; armed = 1; arm_cnt = 0;
            check("start_block", 32'(o_ph_start_block), 32'(job_block));
        end
        if (o_busy) begin
            check("blk_hold", 32'(o_ph_start_block), 32'(job_block));
            check("last_hold", 32'(o_ph_last_phase), 32'(job_last));
        end
        pop = o_out_valid && i_out_ready;
        if (o_ph_rd_en) begin
            check("rd_addr", 32'(o_ph_rd_addr), rd_issued);
            check("rd_occ", 32'((rd_issued - pop_idx - int'(pop)) < 2), 1);
            rd_issued++;
            pending = mem[o_ph_rd_addr];
        end else begin
            pending = '0;
        end
        if (o_out_valid) begin
            ov_cnt++;
            if (first_ov_cyc < 0) first_ov_cyc = cyc;
        end
        if (pop) begin
            if (pop_idx < DEPTH) check("out_data", 32'(o_out_data), 32'(exp_q[pop_idx]));
            else check("extra_pop", pop_idx, DEPTH - 1);
            pop_idx++;
        end
        if (o_result_done) begin res_done_cnt++; res_done_cyc = cyc; end
        if (o_result_fail) begin res_fail_cnt++; res_fail_cyc = cyc; busy_at_fail = o_busy; end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({o_busy, o_in_ready, o_out_valid, o_out_data, o_result_done, o_result_fail,
                    o_ph_start, o_ph_last_phase, o_ph_start_block, o_ph_wr_en, o_ph_wr_addr,
                    o_ph_data_in, o_ph_rd_en, o_ph_rd_addr});
    endfunction

    // rmode: 0 done, 1 fail+done together, 2 silent
    task automatic run_job(input bit rnd_data, input int blk, input bit last, input bit gap,
                           input int omode, input int rmode, input int rdelay,
                           input bit ign, input int rst_pops);
        bit ended = 0;
        bit did_rst = 0;
        for (int i = 0; i < DEPTH; i++) exp_q[i] = rnd_data ? W'($urandom) : W'(i % 16);
        in_idx = 0; wr_seen = 0; rd_issued = 0; pop_idx = 0;
        gap_en = gap; out_mode = omode; resp_mode = rmode; resp_delay = rdelay;
        armed = 0; arm_cnt = 0; pending = '0;
        start_cnt = 0; start_cyc = -1; done_cyc = -1;
        res_done_cnt = 0; res_fail_cnt = 0; res_done_cyc = -1; res_fail_cyc = -1;
        first_ov_cyc = -1; ov_cnt = 0; busy_at_fail = 1;
        job_block = SBW'(blk); job_last = last;
        go_req = 1; ign_go = ign;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (res_done_cnt + res_fail_cnt > 0) begin ended = 1; break; end
            if (rst_pops > 0 && pop_idx == rst_pops) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                check("rst_outs", all_outs(), 0);
                tick(); tick();
                @(negedge clk);
                rst_n = 1'b1;
                armed = 0; pending = '0; did_rst = 1;
                break;
            end
        end
        repeat (3) tick();
        if (did_rst) begin
            check("rst_no_done", res_done_cnt, 0);
            check("rst_no_fail", res_fail_cnt, 0);
            check("rst_idle", 32'(o_busy), 0);
            return;
        end
        check("job_end", 32'(ended), 1);
        check("wr_count", wr_seen, DEPTH);
        check("start_count", start_cnt, 1);
        check("idle_after", 32'(o_busy), 0);
        if (rmode == 0) begin
            check("done_count", res_done_cnt, 1);
            check("fail_count", res_fail_cnt, 0);
            check("pop_count", pop_idx, DEPTH);
            check("rd_count", rd_issued, DEPTH);
            check("first_valid", first_ov_cyc, done_cyc + 3);
            if (omode == 0) check("throughput", res_done_cyc, first_ov_cyc + DEPTH);
        end else if (rmode == 1) begin
            check("fail_count", res_fail_cnt, 1);
            check("fail_time", res_fail_cyc, done_cyc + 1);
            check("fail_busy", 32'(busy_at_fail), 0);
            check("fail_noval", ov_cnt, 0);
            check("fail_done", res_done_cnt, 0);
            check("fail_noread", rd_issued, 0);
        end else begin
            check("to_count", res_fail_cnt, 1);
            check("to_time", res_fail_cyc, start_cyc + 1 + TO);
            check("to_noval", ov_cnt, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i_go = 0; i_go_block = '0; i_go_last = 0;
        i_in_valid = 0; i_in_data = '0; i_out_ready = 0;
        i_ph_done = 0; i_ph_fail = 0; i_ph_data_out = '0;
        go_req = 0; ign_go = 0; armed = 0; pending = '0;
        in_idx = DEPTH; wr_seen = 0; rd_issued = 0; pop_idx = 0;
        job_block = '0; job_last = 0; out_mode = 0; gap_en = 0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outs", all_outs(), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_job(0, 1, 0, 0, 0, 0, 19, 0, 0);   // nominal
        run_job(0, 1, 0, 1, 1, 0, 19, 0, 0);   // backpressure + input gaps
        run_job(0, 2, 1, 0, 0, 1, 5, 0, 0);    // fail with simultaneous done
        run_job(0, 1, 0, 0, 0, 0, 10, 1, 0);   // go during LOAD ignored
        run_job(1, 4, 1, 0, 2, 0, 7, 0, 10);   // reset mid-UNLOAD
        run_job(0, 0, 0, 0, 0, 0, 19, 0, 0);   // clean job after reset
        for (int j = 0; j < 6; j++)
            run_job(1, int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom), 2,
                    ($urandom % 4 == 0) ? 1 : 0, int'($urandom_range(0, 30)), 1'($urandom), 0);
`ifdef PHASE_HOST_TIMEOUT_EN
        run_job(1, 3, 0, 0, 0, 2, 0, 0, 0);    // silent phase engine
        run_job(0, 1, 0, 0, 0, 0, 19, 0, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
